// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw pins, deserializes
// 11-bit device-to-host frames and emits each good byte with a one-cycle strobe.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int                TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]        FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          clk_meta_r;
    logic          clk_sync_r;
    logic          data_meta_r;
    logic          data_sync_r;
    logic          clk_filt_r;
    logic [7:0]    filt_cnt_r;
    logic          fall_tick_r;

    state_t        state_r;
    logic [7:0]    shift_r;
    logic [3:0]    bit_cnt_r;
    logic          parity_r;
    logic [TW-1:0] to_cnt_r;
    logic [7:0]    scan_code_r;
    logic          scan_ready_r;
    logic          frame_err_r;
    logic          rx_busy_r;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Two-flop synchronizers for both pins; the idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock deglitch: the filtered level only follows after FILTER_LEN stable samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt_r  <= 1'b1;
            filt_cnt_r  <= 8'd0;
            fall_tick_r <= 1'b0;
        end else if (clk_sync_r != clk_filt_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                clk_filt_r  <= clk_sync_r;
                filt_cnt_r  <= 8'd0;
                fall_tick_r <= ~clk_sync_r;
            end else begin
                filt_cnt_r  <= filt_cnt_r + 8'd1;
                fall_tick_r <= 1'b0;
            end
        end else begin
            filt_cnt_r  <= 8'd0;
            fall_tick_r <= 1'b0;
        end
    end

    // Frame FSM with timeout supervision; a falling edge always beats the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            shift_r      <= 8'h00;
            bit_cnt_r    <= 4'd0;
            parity_r     <= 1'b0;
            to_cnt_r     <= '0;
            scan_code_r  <= 8'h00;
            scan_ready_r <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_busy_r    <= 1'b0;
        end else begin
            scan_ready_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (state_r == S_IDLE) begin
                to_cnt_r <= '0;
                if (fall_tick_r && !data_sync_r) begin
                    shift_r   <= 8'h00;
                    bit_cnt_r <= 4'd0;
                    state_r   <= S_DATA;
                    rx_busy_r <= 1'b1;
                end else begin
                    rx_busy_r <= 1'b0;
                end
            end else if (fall_tick_r) begin
                to_cnt_r <= '0;
                case (state_r)
                    S_DATA: begin
                        shift_r   <= {data_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            state_r <= S_PARITY;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                    S_PARITY: begin
                        parity_r <= data_sync_r;
                        state_r  <= S_STOP;
                    end
                    S_STOP: begin
                        if (odd_parity_ok(shift_r, parity_r) && data_sync_r) begin
                            scan_code_r  <= shift_r;
                            scan_ready_r <= 1'b1;
                        end else begin
                            frame_err_r  <= 1'b1;
                        end
                        state_r   <= S_IDLE;
                        rx_busy_r <= 1'b0;
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        rx_busy_r <= 1'b0;
                    end
                endcase
            end else if (to_cnt_r == TO_LAST) begin
                to_cnt_r    <= '0;
                frame_err_r <= 1'b1;
                state_r     <= S_IDLE;
                rx_busy_r   <= 1'b0;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
        end
    end

    assign scan_code  = scan_code_r;
    assign scan_ready = scan_ready_r;
    assign frame_err  = frame_err_r;
    assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: table-driven frames, randomized frames against
// a parity-rule model, plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 200;
    localparam int HP = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int rdy_cyc = 0;
    int err_cyc = 0;
    int last_fall = 0;
    bit busy_seen = 1'b0;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .scan_ready(scan_ready),
        .frame_err(frame_err), .rx_busy(rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (scan_ready) begin
                rdy_cnt = rdy_cnt + 1;
                rdy_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt = err_cnt + 1;
                err_cyc = cyc;
            end
            if (scan_ready || frame_err) begin
                checks = checks + 1;
                if (scan_ready && frame_err) begin
                    errors = errors + 1;
                    $display("FAIL exclusive_pulses: scan_ready=%0b frame_err=%0b, required not both", scan_ready, frame_err);
                end
            end
            if (rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first n bits of an 11-bit frame (bit 0 = start) with HP-cycle phases.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HP / 2);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_cyc(HP);
            ps2_clk = 1'b1;
            wait_cyc(HP / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input int n);
        logic par;
        par = ~(^d) ^ flip;
        send_bits({stop, par, d, 1'b0}, n);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        int         exp_rdy;
        int         exp_err;
        logic [7:0] exp_code;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int r0, e0;
        logic [7:0] d;
        logic flip, stop, par, good;
        logic [7:0] model_code;

        tbl[0] = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D};
        tbl[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0};
        tbl[2] = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D};
        tbl[3] = '{8'h43, 1'b1, 1'b1, 0, 1, 8'h1D};
        tbl[4] = '{8'h42, 1'b0, 1'b0, 0, 1, 8'h1D};

        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(4);
        chk("reset_scan_code", scan_code, 8'h00);
        chk("reset_scan_ready", scan_ready, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Table frames, sent with short gaps (F0 then 1D back to back).
        for (int i = 0; i < 5; i++) begin
            r0 = rdy_cnt;
            e0 = err_cnt;
            send_frame(tbl[i].data, tbl[i].flip, tbl[i].stop, 11);
            wait_cyc(FL + 8);
            chk($sformatf("tbl%0d_ready", i), rdy_cnt - r0, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].exp_err);
            chk($sformatf("tbl%0d_code", i), scan_code, tbl[i].exp_code);
            if (i == 0) chk_range("ready_latency", rdy_cyc - last_fall, FL + 2, FL + 4);
            chk($sformatf("tbl%0d_busy_after", i), rx_busy, 0);
        end
        model_code = 8'h1D;

        // rx_busy rises only after the start bit edge has been filtered.
        ps2_data = 1'b0;
        wait_cyc(HP / 2);
        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        chk("busy_before_start", rx_busy, 0);
        wait_cyc(6);
        chk("busy_after_start", rx_busy, 1);
        wait_cyc(HP - FL - 5);
        ps2_clk = 1'b1;
        wait_cyc(HP / 2);
        r0 = rdy_cnt;
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0} >> 1, 10);
        wait_cyc(FL + 8);
        chk("busy_frame_ready", rdy_cnt - r0, 1);
        chk("busy_frame_code", scan_code, 8'h5A);
        model_code = 8'h5A;

        // Randomized frames against the parity/stop rule.
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 3) != 0);
            par = ~(^d) ^ flip;
            good = ((^d) ^ par) && stop;
            if (good) model_code = d;
            r0 = rdy_cnt;
            e0 = err_cnt;
            send_frame(d, flip, stop, 11);
            wait_cyc(FL + 8);
            chk($sformatf("rnd%0d_ready", i), rdy_cnt - r0, good ? 1 : 0);
            chk($sformatf("rnd%0d_err", i), err_cnt - e0, good ? 0 : 1);
            chk($sformatf("rnd%0d_code", i), scan_code, model_code);
        end

        // Partial frame then clock stops: timeout abandons it.
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_frame(8'h15, 1'b0, 1'b1, 6);
        for (int k = 0; k < TO + FL + 60 && err_cnt == e0; k++) wait_cyc(1);
        chk("timeout_err", err_cnt - e0, 1);
        chk_range("timeout_latency", err_cyc - last_fall, TO + FL + 2, TO + FL + 4);
        chk("timeout_ready", rdy_cnt - r0, 0);
        chk("timeout_busy", rx_busy, 0);
        chk("timeout_code", scan_code, model_code);
        r0 = rdy_cnt;
        send_frame(8'h1B, 1'b0, 1'b1, 11);
        wait_cyc(FL + 8);
        chk("after_timeout_ready", rdy_cnt - r0, 1);
        chk("after_timeout_code", scan_code, 8'h1B);

        // Short low glitch with data low while idle must not start a frame.
        r0 = rdy_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        ps2_data = 1'b0;
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(FL - 2);
        ps2_clk = 1'b1;
        wait_cyc(4);
        ps2_data = 1'b1;
        wait_cyc(TO + 40);
        chk("glitch_busy", busy_seen, 0);
        chk("glitch_err", err_cnt - e0, 0);
        chk("glitch_ready", rdy_cnt - r0, 0);

        // Reset after four data bits: outputs clear immediately, no stray pulses after.
        send_frame(8'h1D, 1'b0, 1'b1, 5);
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_scan_code", scan_code, 8'h00);
        chk("midrst_scan_ready", scan_ready, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_rx_busy", rx_busy, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        r0 = rdy_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        wait_cyc(TO + 40);
        chk("postrst_quiet_err", err_cnt - e0, 0);
        chk("postrst_quiet_busy", busy_seen, 0);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        wait_cyc(FL + 8);
        chk("postrst_ready", rdy_cnt - r0, 1);
        chk("postrst_code", scan_code, 8'h1D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
